clk_step_ctrl: RTL and testbench



---
 rtl/clk_step_ctrl.sv | 117 +++++++++++
 tb/tb_clk_step_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// Single-domain clock-enable scheduler: issues a one-cycle pipe_en pulse every
// 2^sel_q cycles and sequences the core through halt, free-run and single-step.
module clk_step_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_SEL = 24,
  parameter int unsigned SCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [4:0]        div_sel,
  input  logic              cfg_load,
  input  logic              step_btn,
  input  logic              core_halt,
  output logic              pipe_en,
  output logic              led,
  output logic [1:0]        state,
  output logic [SCNT_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    ST_HALT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_ARMED     = 2'b10,
    ST_CORE_HALT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    M_HALT     = 2'b00,
    M_RUN      = 2'b01,
    M_STEP     = 2'b10,
    M_ALT_HALT = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  logic [4:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic             step_q;
  logic             step_edge;
  logic             tick;
  logic             fire;
  logic             halt_mode;

  assign period_m1 = (CNT_W'(1) << sel_q) - CNT_W'(1);
  assign tick      = (cnt == period_m1);
  assign step_edge = step_btn & ~step_q;
  assign halt_mode = (mode == M_HALT) || (mode == M_ALT_HALT);

  // Priority order inside each state matters: core_halt beats mode, mode beats tick.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (mode == M_RUN)
          state_d = ST_RUN;
        else if ((mode == M_STEP) && step_edge)
          state_d = ST_ARMED;
      end
      ST_RUN: begin
        if (core_halt)
          state_d = ST_CORE_HALT;
        else if (mode != M_RUN)
          state_d = ST_HALT;
        else if (tick)
          fire = 1'b1;
      end
      ST_ARMED: begin
        if (core_halt)
          state_d = ST_CORE_HALT;
        else if (halt_mode)
          state_d = ST_HALT;
        else if (mode == M_RUN)
          state_d = ST_RUN;
        else if (tick) begin
          fire    = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_CORE_HALT: begin
        if (halt_mode)
          state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALT;
      sel_q     <= 5'(DEF_SEL);
      cnt       <= '0;
      step_q    <= 1'b0;
      pipe_en   <= 1'b0;
      led       <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_btn;
      pipe_en <= fire;
      if (cfg_load)
        sel_q <= div_sel;
      if (cfg_load || (state_d != state_q) || tick)
        cnt <= '0;
      else if ((state_q == ST_RUN) || (state_q == ST_ARMED))
        cnt <= cnt + CNT_W'(1);
      if (fire) begin
        led       <= ~led;
        pulse_cnt <= pulse_cnt + SCNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: expected pulse cycles are queued when
// stimulus is driven and matched against each observed pipe_en pulse.
module tb_clk_step_ctrl;

  localparam int unsigned SCNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic [4:0]        div_sel = '0;
  logic              cfg_load = 1'b0;
  logic              step_btn = 1'b0;
  logic              core_halt = 1'b0;
  logic              pipe_en;
  logic              led;
  logic [1:0]        state;
  logic [SCNT_W-1:0] pulse_cnt;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned exp_q[$];

  clk_step_ctrl #(.CNT_W(32), .DEF_SEL(24), .SCNT_W(SCNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .div_sel   (div_sel),
    .cfg_load  (cfg_load),
    .step_btn  (step_btn),
    .core_halt (core_halt),
    .pipe_en   (pipe_en),
    .led       (led),
    .state     (state),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every pulse must match the next queued cycle number.
  always @(negedge clk) begin
    if (pipe_en === 1'b1) begin
      if (exp_q.size() == 0)
        check("pulse_unexp", cyc, 32'hFFFF_FFFF);
      else
        check("pulse_cyc", cyc, exp_q.pop_front());
    end
  end

  task automatic cycle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) cycle(1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mode      = 2'b00;
    cfg_load  = 1'b0;
    step_btn  = 1'b0;
    core_halt = 1'b0;
    div_sel   = '0;
    cycle(2);
    rst = 1'b0;
  endtask

  task automatic load(input logic [4:0] s);
    div_sel  = s;
    cfg_load = 1'b1;
    cycle(1);
    cfg_load = 1'b0;
  endtask

  // Enter RUN from HALT, expect n pulses, then drop back to HALT on the last pulse.
  task automatic run_pulses(input int unsigned s, input int unsigned n);
    int unsigned d, p, last;
    d = cyc;
    p = 1 << s;
    mode = 2'b01;
    for (int unsigned k = 0; k < n; k++) exp_q.push_back(d + p + 1 + k * p);
    last = d + p + 1 + (n - 1) * p;
    wait_until(last);
    mode = 2'b00;
    cycle(3);
    check("q_drain", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned d, s, l;
    cycle(1);

    // Reset and idle
    do_reset();
    check("rst_state", state, 0);
    check("rst_pipe_en", pipe_en, 0);
    check("rst_led", led, 0);
    check("rst_pulse_cnt", pulse_cnt, 0);
    cycle(100);
    check("idle_state", state, 0);
    check("idle_led", led, 0);
    check("idle_pulse_cnt", pulse_cnt, 0);

    // Free-run at sel 0 then sel 2
    load(0);
    run_pulses(0, 5);
    load(2);
    run_pulses(2, 5);
    check("run_pulse_cnt", pulse_cnt, 10);
    check("run_led", led, 0);
    check("run_state", state, 0);

    // Single step at sel 3 with a second edge while armed
    do_reset();
    load(3);
    mode = 2'b10;
    cycle(2);
    s = cyc;
    step_btn = 1'b1;
    exp_q.push_back(s + 9);
    cycle(2);
    check("step_armed", state, 2);
    step_btn = 1'b0;
    cycle(1);
    step_btn = 1'b1;
    cycle(1);
    step_btn = 1'b0;
    wait_until(s + 12);
    check("step_state", state, 0);
    check("step_pulse_cnt", pulse_cnt, 1);
    check("step_q_drain", exp_q.size(), 0);

    // Core halt coinciding with a tick
    do_reset();
    mode = 2'b00;
    load(0);
    d = cyc;
    mode = 2'b01;
    exp_q.push_back(d + 2);
    exp_q.push_back(d + 3);
    wait_until(d + 3);
    core_halt = 1'b1;
    cycle(1);
    core_halt = 1'b0;
    check("ch_state", state, 3);
    cycle(5);
    check("ch_hold", state, 3);
    check("ch_q_drain", exp_q.size(), 0);
    mode = 2'b00;
    cycle(1);
    check("ch_exit", state, 0);
    check("ch_pulse_cnt", pulse_cnt, 2);

    // cfg_load while armed restarts the count
    do_reset();
    mode = 2'b10;
    cycle(1);
    s = cyc;
    step_btn = 1'b1;
    cycle(1);
    step_btn = 1'b0;
    cycle(2);
    check("ld_armed", state, 2);
    l = cyc;
    div_sel  = 5'd1;
    cfg_load = 1'b1;
    exp_q.push_back(l + 3);
    cycle(1);
    cfg_load = 1'b0;
    wait_until(l + 5);
    check("ld_state", state, 0);
    check("ld_q_drain", exp_q.size(), 0);
    check("ld_pulse_cnt", pulse_cnt, 1);

    // Reset mid-run
    do_reset();
    load(0);
    d = cyc;
    mode = 2'b01;
    for (int unsigned k = 0; k < 5; k++) exp_q.push_back(d + 2 + k);
    wait_until(d + 6);
    check("mr_pulse_cnt", pulse_cnt, 5);
    check("mr_led", led, 1);
    check("mr_state", state, 1);
    rst  = 1'b1;
    mode = 2'b00;
    cycle(1);
    rst = 1'b0;
    check("mr_rst_state", state, 0);
    check("mr_rst_pipe_en", pipe_en, 0);
    check("mr_rst_led", led, 0);
    check("mr_rst_pulse_cnt", pulse_cnt, 0);
    cycle(2);
    check("mr_q_drain", exp_q.size(), 0);

    // pulse_cnt wrap with a 4-bit counter
    do_reset();
    load(0);
    run_pulses(0, 17);
    check("wrap_pulse_cnt", pulse_cnt, 1);
    check("wrap_led", led, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
